// File: rtl/dead_time_gen_multi.sv
// dead_time_gen_multi
// Complementary high/low gate drive for CHANNELS half-bridges. Each channel
// inserts a programmable both-off gap (rise and fall set independently)
// before switching sides. A latched fault or a low global enable parks
// every channel in IDLE with both switches off.
// All gate outputs come straight from flops loaded with a decode of the
// next state, so they cannot glitch and can never be on together.
module dead_time_gen_multi #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                MClk,
    input  logic                Rst,
    input  logic                En,
    input  logic [CNT_W-1:0]    DeadTimeRise,
    input  logic [CNT_W-1:0]    DeadTimeFall,
    input  logic [CHANNELS-1:0] PwmIn,
    input  logic                Fault,
    input  logic                FaultClr,
    output logic [CHANNELS-1:0] HiOut,
    output logic [CHANNELS-1:0] LoOut,
    output logic [CHANNELS-1:0] DtActive,
    output logic                FaultLatched
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DT    = 2'd1,
        HI_ON = 2'd2,
        LO_ON = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Anything that must hold every channel off. A live Fault acts on the
    // same edge it is sampled, before the latch itself has updated.
    logic force_idle;
    assign force_idle = Fault | FaultLatched | ~En;

    // Sticky fault flag: set wins over clear, clear only when Fault is gone.
    always_ff @(posedge MClk) begin
        if (Rst) begin
            FaultLatched <= 1'b0;
        end else if (Fault) begin
            FaultLatched <= 1'b1;
        end else if (FaultClr) begin
            FaultLatched <= 1'b0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           st, st_nxt;
        logic             tgt, tgt_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             hi_q, lo_q, dt_q;
        logic             pwm;

        assign pwm = PwmIn[g];

        // Next-state logic: dead-time values are only sampled on a load,
        // so a change mid-count leaves the running gap untouched.
        always_comb begin
            st_nxt  = st;
            tgt_nxt = tgt;
            cnt_nxt = cnt;
            if (force_idle) begin
                st_nxt = IDLE;
            end else begin
                case (st)
                    IDLE: begin
                        tgt_nxt = pwm;
                        cnt_nxt = pwm ? DeadTimeRise : DeadTimeFall;
                        st_nxt  = DT;
                    end
                    DT: begin
                        if (pwm != tgt) begin
                            // Command flipped during the gap: restart toward the new side.
                            tgt_nxt = pwm;
                            cnt_nxt = pwm ? DeadTimeRise : DeadTimeFall;
                        end else if (cnt <= CNT_ONE) begin
                            st_nxt = tgt ? HI_ON : LO_ON;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                    HI_ON: begin
                        if (!pwm) begin
                            tgt_nxt = 1'b0;
                            cnt_nxt = DeadTimeFall;
                            st_nxt  = DT;
                        end
                    end
                    LO_ON: begin
                        if (pwm) begin
                            tgt_nxt = 1'b1;
                            cnt_nxt = DeadTimeRise;
                            st_nxt  = DT;
                        end
                    end
                    default: st_nxt = IDLE;
                endcase
            end
        end

        // State, target and counter registers.
        always_ff @(posedge MClk) begin
            if (Rst) begin
                st  <= IDLE;
                tgt <= 1'b0;
                cnt <= '0;
            end else begin
                st  <= st_nxt;
                tgt <= tgt_nxt;
                cnt <= cnt_nxt;
            end
        end

        // Registered gate and dead-time flags decoded from the next state.
        always_ff @(posedge MClk) begin
            if (Rst) begin
                hi_q <= 1'b0;
                lo_q <= 1'b0;
                dt_q <= 1'b0;
            end else begin
                hi_q <= (st_nxt == HI_ON);
                lo_q <= (st_nxt == LO_ON);
                dt_q <= (st_nxt == DT);
            end
        end

        assign HiOut[g]    = hi_q;
        assign LoOut[g]    = lo_q;
        assign DtActive[g] = dt_q;
    end

endmodule
